// File: rtl/systolic_result_drain_pkg.sv
// Shared types for the systolic result drain: collector states and the packed 2x2 tile.
package systolic_result_drain_pkg;

    localparam int TILE_DW = 32;

    typedef enum logic [1:0] {
        S_WAIT11   = 2'd0,
        S_WAITEDGE = 2'd1,
        S_WAIT22   = 2'd2
    } coll_state_e;

    typedef struct packed {
        logic [TILE_DW-1:0] c11;
        logic [TILE_DW-1:0] c12;
        logic [TILE_DW-1:0] c21;
        logic [TILE_DW-1:0] c22;
    } tile_t;

    // Word order on the output stream is c11, c12, c21, c22.
    function automatic logic [TILE_DW-1:0] tile_word(input tile_t t, input logic [1:0] idx);
        logic [TILE_DW-1:0] w;
        case (idx)
            2'd0:    w = t.c11;
            2'd1:    w = t.c12;
            2'd2:    w = t.c21;
            default: w = t.c22;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/systolic_result_drain_tile_fifo.sv
// Synchronous FIFO of packed tiles; wrap-bit pointers distinguish full from empty.
module systolic_result_drain_tile_fifo
    import systolic_result_drain_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  clear_i,
    input  logic  push_i,
    input  tile_t tile_i,
    input  logic  pop_i,
    output logic  full_o,
    output logic  empty_o,
    output tile_t head_o
);

    localparam int AW = $clog2(DEPTH);

    tile_t       mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= tile_i;
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures 2x2 result tiles on the push11/pushedge/push22 strobes and streams them as words.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int TILE_DEPTH = 4,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          push11,
    input  logic          pushedge,
    input  logic          push22,
    input  logic [DW-1:0] c11,
    input  logic [DW-1:0] c12,
    input  logic [DW-1:0] c21,
    input  logic [DW-1:0] c22,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_tile_end,
    output logic [31:0]   tile_count,
    output logic          overflow,
    output logic          seq_err
);

    coll_state_e   state_q, state_d;
    logic [DW-1:0] c11_q, c11_d;
    logic [DW-1:0] c12_q, c12_d;
    logic [DW-1:0] c21_q, c21_d;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   tile_count_q, tile_count_d;
    logic          overflow_q, overflow_d;
    logic          seq_err_q, seq_err_d;

    logic [1:0]    n_stb;
    logic          err_set;
    logic          tile_push;
    logic          accept, drop;
    logic          hs, pop;
    logic          fifo_full, fifo_empty;
    tile_t         new_tile, head_tile;

    assign n_stb = {1'b0, push11} + {1'b0, pushedge} + {1'b0, push22};

    always_comb begin
        state_d   = state_q;
        c11_d     = c11_q;
        c12_d     = c12_q;
        c21_d     = c21_q;
        err_set   = 1'b0;
        tile_push = 1'b0;
        if (n_stb > 2'd1) begin
            err_set = 1'b1;
            state_d = S_WAIT11;
        end else if (push11) begin
            // Legal from any state: a fresh push11 restarts capture.
            c11_d   = c11;
            state_d = S_WAITEDGE;
        end else if (pushedge) begin
            if (state_q == S_WAITEDGE) begin
                c12_d   = c12;
                c21_d   = c21;
                state_d = S_WAIT22;
            end else begin
                err_set = 1'b1;
                state_d = S_WAIT11;
            end
        end else if (push22) begin
            if (state_q == S_WAIT22) begin
                tile_push = 1'b1;
            end else begin
                err_set = 1'b1;
            end
            state_d = S_WAIT11;
        end
    end

    assign new_tile = '{c11: c11_q, c12: c12_q, c21: c21_q, c22: c22};

    // Output stream: head tile serialized by the word index.
    assign out_valid    = !fifo_empty;
    assign out_data     = out_valid ? tile_word(head_tile, idx_q) : '0;
    assign out_tile_end = out_valid && (idx_q == 2'd3);
    assign hs           = out_valid && out_ready;
    assign pop          = hs && (idx_q == 2'd3);

    // A full FIFO still takes the tile when the head leaves in the same cycle.
    assign accept = tile_push && (!fifo_full || pop);
    assign drop   = tile_push && fifo_full && !pop;

    always_comb begin
        idx_d        = hs ? idx_q + 2'd1 : idx_q;
        tile_count_d = accept ? tile_count_q + 32'd1 : tile_count_q;
        overflow_d   = overflow_q | drop;
        seq_err_d    = seq_err_q | err_set;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_WAIT11;
            c11_q        <= '0;
            c12_q        <= '0;
            c21_q        <= '0;
            idx_q        <= '0;
            tile_count_q <= '0;
            overflow_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else if (start) begin
            state_q      <= S_WAIT11;
            c11_q        <= '0;
            c12_q        <= '0;
            c21_q        <= '0;
            idx_q        <= '0;
            tile_count_q <= '0;
            overflow_q   <= 1'b0;
            seq_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            c11_q        <= c11_d;
            c12_q        <= c12_d;
            c21_q        <= c21_d;
            idx_q        <= idx_d;
            tile_count_q <= tile_count_d;
            overflow_q   <= overflow_d;
            seq_err_q    <= seq_err_d;
        end
    end

    assign tile_count = tile_count_q;
    assign overflow   = overflow_q;
    assign seq_err    = seq_err_q;

    systolic_result_drain_tile_fifo #(
        .DEPTH (TILE_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear_i (start),
        .push_i  (accept && !start),
        .tile_i  (new_tile),
        .pop_i   (pop && !start),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (head_tile)
    );

endmodule
